fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the MIPS core, directly upstream of the main control decoder. It holds the PC, runs a request/acknowledge handshake with instruction memory and latches the returned word. It presents the instruction and its opcode field to decode until the downstream stage consumes it, and accepts PC redirects from branch/jump/JR resolution.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request; held until `imem_ack`.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: memory response valid this cycle; sampled only while `imem_req`=1.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` / `opcode` / `pc_plus4` valid for decode.
- `opcode` out 6: always equals `instr[31:26]`; feeds control.
- `pc_plus4` out 32: address of `instr` + 4 (for JAL link and branch base).
- `stall` in 1: downstream not ready; the instruction is consumed on an edge where `instr_valid`=1 and `stall`=0.
- `redirect` in 1: load a new PC (taken branch, J, JAL, JR).
- `redirect_pc` in 32: target; bits [1:0] are ignored and forced to 0.

## Operation
- **States:**
  - IDLE: reset state.
  - REQ: `imem_req`=1.
  - HOLD: `instr_valid`=1.
- **IDLE:** goes to REQ on the first rising edge after `rst_n` rises.
- **REQ:** `imem_addr`=pc.
  - On `imem_ack`: `instr`←`imem_rdata`, `pc_plus4`←pc+4, pc←pc+4, go to HOLD.
- **HOLD:** the outputs are held while `stall`=1. On the consume edge, go to REQ.
- **Redirect:** `redirect` has priority over `stall` and over any completion.
  - **In HOLD:** pc←target, `instr_valid`←0, go to REQ.
  - **In REQ with `imem_ack` on the same edge:** discard the word, pc←target, stay in REQ.
  - **In REQ without `imem_ack`:** the request cannot be withdrawn.
    - Hold `imem_req` and `imem_addr` and set `squash`; the target is captured in pc_next.
    - The acked word is discarded, `squash` clears, and the block re-enters REQ at the target.
    - A second redirect during squash overwrites pc_next (last wins).
  - **In IDLE:** pc←target.
- **PC arithmetic:** 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- **Outputs with `instr_valid`=0:** `instr`/`opcode` keep their last value; decode must qualify with `instr_valid`.

## Timing
- **Reset values:**
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `instr`=0 (NOP), `opcode`=0, `instr_valid`=0
  - `pc_plus4`=`RESET_PC`+4, `squash`=0
- **Reset behaviour:** reset acts immediately and asynchronously, including mid-handshake. An ack arriving during or after reset is ignored.
- **Output timing:** all outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- **Latency:**
  - The ack edge is followed by `instr_valid`=1 in the next cycle.
  - Zero-wait memory and no stall give 1 instruction per 2 cycles (REQ, HOLD).
- **Redirect to new request:** 1 cycle after `redirect` (0 extra cycles if REQ was not outstanding), plus the memory latency of any squashed request.

## Configuration
- **`FETCH_JUMP_PREDECODE_EN`:**
  - **Defined:** on the ack edge, if `imem_rdata[31:26]` is 6'h02 (J) or 6'h03 (JAL), the unit loads pc←{(pc+4)[31:28], `imem_rdata[25:0]`, 2'b00} instead of pc+4.
    - `pc_plus4` is still the sequential address.
    - A later external `redirect` for the same jump is redundant but harmless, since it reloads the same pc.
  - **Undefined:** the unit fetches sequentially after J/JAL until an external `redirect` arrives.

## Test plan
- **Reset fetch:** `RESET_PC`=0x100, memory acks 1 cycle after req with 0x2008_0005. Expect `imem_addr`=0x100, then `instr_valid`=1, `opcode`=6'h08, `pc_plus4`=0x104, next req at 0x104.
- **Stall hold:** stall=1 for 5 cycles during HOLD. Expect `instr` stable, no `imem_req`; req at 0x108 one cycle after stall drops.
- **Squash:** redirect to 0x400 while the req at 0x108 is outstanding, ack after 3 cycles. Expect `imem_addr` held at 0x108, word discarded (`instr_valid` stays 0), next req at 0x400.
- **Redirect priority:** redirect to 0x203 in HOLD with stall=1. Expect `instr_valid`→0 and next req at 0x200.
- **Wrap:** `RESET_PC`=0xFFFF_FFFC. Expect `pc_plus4`=0 and next fetch at 0x0.
- **Predecode, macro on:** ack 0x0800_0040 (J) at pc 0x100. Expect next req at 0x100 without redirect. With the macro off, expect the next req at 0x104.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage with imem req/ack handshake and PC redirect.
// Optional macro FETCH_JUMP_PREDECODE_EN: follow J/JAL targets directly on the ack edge.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        squash;
  logic        ack_in;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] fetch_pc;

  assign ack_in = (state == REQ) && imem_ack;
  assign target = redirect_pc & ~32'h3;
  assign seq_pc = pc + 32'd4;

`ifdef FETCH_JUMP_PREDECODE_EN
  // J (6'h02) and JAL (6'h03) resolve their target from the fetched word alone.
  assign fetch_pc = (imem_rdata[31:27] == 5'b00001) ?
                    {seq_pc[31:28], imem_rdata[25:0], 2'b00} : seq_pc;
`else
  assign fetch_pc = seq_pc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack && !squash && !redirect) state_nxt = HOLD;
      HOLD:    if (redirect || !stall) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == REQ);
    instr_valid = (state == HOLD);
  end

  // A redirect against an outstanding request parks the target in pc_next until the ack retires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pc_next  <= RESET_PC;
      squash   <= 1'b0;
      instr    <= 32'h0;
      pc_plus4 <= RESET_PC + 32'd4;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= target;
        end
        REQ: begin
          if (squash) begin
            if (ack_in) begin
              squash <= 1'b0;
              pc     <= redirect ? target : pc_next;
            end else if (redirect) begin
              pc_next <= target;
            end
          end else if (ack_in) begin
            if (redirect) begin
              pc <= target;
            end else begin
              instr    <= imem_rdata;
              pc_plus4 <= seq_pc;
              pc       <= fetch_pc;
            end
          end else if (redirect) begin
            squash  <= 1'b1;
            pc_next <= target;
          end
        end
        HOLD: begin
          if (redirect) pc <= target;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios, then randomized traffic vs a reference model.
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int total = 0;
  int bad = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .pc_plus4(pc_plus4),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference model: where the fetcher is in its life cycle, expressed as plain flags.
  bit          m_idle, m_req, m_valid, m_discard;
  logic [31:0] m_addr, m_instr, m_pc4, m_after_discard;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_fetch(input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] seq;
    seq = addr + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (word[31:26] == 6'h02 || word[31:26] == 6'h03)
      return {seq[31:28], word[25:0], 2'b00};
`endif
    return seq;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_req = 0; m_valid = 0; m_discard = 0;
    m_addr = RESET_PC; m_instr = 32'h0; m_pc4 = RESET_PC + 32'd4; m_after_discard = RESET_PC;
  endtask

  task automatic model_edge(input bit ack, input bit stl, input bit redir,
                            input logic [31:0] tgt, input logic [31:0] word);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (m_idle) begin
      m_idle = 0;
      m_req  = 1;
      if (redir) m_addr = t;
    end else if (m_req) begin
      if (ack) begin
        if (m_discard) begin
          m_discard = 0;
          m_addr = redir ? t : m_after_discard;
        end else if (redir) begin
          m_addr = t;
        end else begin
          m_instr = word;
          m_pc4   = m_addr + 32'd4;
          m_addr  = next_fetch(m_addr, word);
          m_req   = 0;
          m_valid = 1;
        end
      end else if (redir) begin
        m_discard = 1;
        m_after_discard = t;
      end
    end else if (m_valid) begin
      if (redir) begin
        m_addr = t; m_valid = 0; m_req = 1;
      end else if (!stl) begin
        m_valid = 0; m_req = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("req", {31'h0, imem_req}, {31'h0, m_req});
    if (m_req) check("addr", imem_addr, m_addr);
    check("valid", {31'h0, instr_valid}, {31'h0, m_valid});
    check("instr", instr, m_instr);
    check("opcode", {26'h0, opcode}, {26'h0, m_instr[31:26]});
    check("pc_plus4", pc_plus4, m_pc4);
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
  task automatic step(input bit ack, input bit stl, input bit redir,
                      input logic [31:0] tgt, input logic [31:0] word);
    imem_ack = ack; stall = stl; redirect = redir; redirect_pc = tgt; imem_rdata = word;
    @(posedge clk);
    model_edge(ack, stl, redir, tgt, word);
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_opcode"}, {26'h0, opcode}, 32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_pc4"}, pc_plus4, RESET_PC + 32'd4);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Reset fetch
    step(0, 0, 0, 0, 0);
    check("first_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0, 32'h2008_0005);
    check("first_valid", {31'h0, instr_valid}, 32'h1);
    check("first_opcode", {26'h0, opcode}, 32'h08);
    check("first_pc4", pc_plus4, 32'h104);
    step(0, 0, 0, 0, 0);
    check("second_addr", imem_addr, 32'h104);
    step(1, 0, 0, 0, 32'h0000_0000);

    // Stall hold
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 32'hDEAD_BEEF);
      check("stall_instr", instr, 32'h0000_0000);
      check("stall_noreq", {31'h0, imem_req}, 32'h0);
    end
    step(0, 0, 0, 0, 0);
    check("after_stall_addr", imem_addr, 32'h108);

    // Squash
    step(0, 0, 1, 32'h400, 0);
    check("squash_hold_addr", imem_addr, 32'h108);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("squash_hold_addr2", imem_addr, 32'h108);
    step(1, 0, 0, 0, 32'h1111_1111);
    check("squash_discard", {31'h0, instr_valid}, 32'h0);
    check("squash_new_addr", imem_addr, 32'h400);

    // Redirect priority over stall in HOLD
    step(1, 0, 0, 0, 32'h8C00_0000);
    step(0, 1, 1, 32'h203, 0);
    check("prio_valid", {31'h0, instr_valid}, 32'h0);
    check("prio_addr", imem_addr, 32'h200);

    // Wrap (redirect coinciding with ack discards the word)
    step(1, 0, 1, 32'hFFFF_FFFC, 32'h2222_2222);
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 32'h2400_0000);
    check("wrap_pc4", pc_plus4, 32'h0);
    step(0, 0, 0, 0, 0);
    check("wrap_next", imem_addr, 32'h0);

    // Jump predecode
    step(1, 0, 1, 32'h100, 32'h3333_3333);
    step(1, 0, 0, 0, 32'h0800_0040);
    check("j_pc4", pc_plus4, 32'h104);
    step(0, 0, 0, 0, 0);
`ifdef FETCH_JUMP_PREDECODE_EN
    check("j_next", imem_addr, 32'h100);
`else
    check("j_next", imem_addr, 32'h104);
`endif

    // Asynchronous reset mid-handshake, with ack present during reset
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    #1 rst_n = 1'b0;
    #1 check_reset_values("async");
    @(posedge clk);
    @(negedge clk);
    check_reset_values("held");
    imem_ack = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 10) == 0,
           $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
